traffic_phase_controller: RTL and testbench

Parametrised two-approach traffic/pedestrian phase sequencer. It replaces manual switch stepping with timed phases derived from an internal tick divider, and adds:
- latched pedestrian push-button requests;
- a walk / flashing don't-walk / steady don't-walk sequence;
- a guarded manual advance input.

It sits between the board-level clock/switch inputs and the GPIO lamp drivers.

---
 rtl/traffic_phase_controller.sv | 203 ++++++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: two-approach traffic/pedestrian phase sequencer.
// Phase timing is derived from an internal tick divider. Pedestrian push-button
// requests are latched and served with walk / flashing / steady don't-walk
// during the matching green. A manual advance can end a green early, but it
// is ignored while walk or flash is shown.
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-high reset
//   enable      1 = run, 0 = freeze all state and outputs
//   ped_req1/2  pedestrian buttons (level, sampled every cycle)
//   force_next  single-cycle request to end the current green early
//   t1/t2       approach lamps {red, yellow, green}
//   p1/p2       pedestrian lamps {dont_walk, walk}
//   ped_wait1/2 pending-request latches
//   state       current phase encoding
//   remaining   ticks left in the current phase minus one
module traffic_phase_controller #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned GREEN_TICKS  = 20,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned WALK_TICKS   = 8,
    parameter int unsigned FLASH_TICKS  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ped_req1,
    input  logic             ped_req2,
    input  logic             force_next,
    output logic [2:0]       t1,
    output logic [2:0]       t2,
    output logic [1:0]       p1,
    output logic [1:0]       p2,
    output logic             ped_wait1,
    output logic             ped_wait2,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] remaining
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        PH_G1 = 3'd0,
        PH_Y1 = 3'd1,
        PH_R1 = 3'd2,
        PH_G2 = 3'd3,
        PH_Y2 = 3'd4,
        PH_R2 = 3'd5
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   elapsed_q, elapsed_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               served_q, served_d;
    logic               blink_q, blink_d;
    logic               wait1_d, wait2_d;
    logic               tick, force_ok;
    logic [2:0]         t1_d, t2_d;
    logic [1:0]         p1_d, p2_d;
    logic [CNT_W-1:0]   remaining_d;

    function automatic logic [CNT_W-1:0] phase_len(input phase_t ph);
        case (ph)
            PH_G1, PH_G2: phase_len = CNT_W'(GREEN_TICKS);
            PH_Y1, PH_Y2: phase_len = CNT_W'(YELLOW_TICKS);
            default:      phase_len = CNT_W'(ALLRED_TICKS);
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_G1:   next_phase = PH_Y1;
            PH_Y1:   next_phase = PH_R1;
            PH_R1:   next_phase = PH_G2;
            PH_G2:   next_phase = PH_Y2;
            PH_Y2:   next_phase = PH_R2;
            default: next_phase = PH_G1;
        endcase
    endfunction

    // Pedestrian lamp for a served green at the given elapsed tick count.
    function automatic logic [1:0] ped_lamp(input logic [CNT_W-1:0] el, input logic bl);
        if (el < CNT_W'(WALK_TICKS))
            ped_lamp = 2'b01;
        else if (el < CNT_W'(WALK_TICKS + FLASH_TICKS))
            ped_lamp = {bl, 1'b0};
        else
            ped_lamp = 2'b10;
    endfunction

    // State register plus registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q   <= PH_R2;
            elapsed_q <= '0;
            div_q     <= '0;
            served_q  <= 1'b0;
            blink_q   <= 1'b0;
            ped_wait1 <= 1'b0;
            ped_wait2 <= 1'b0;
            t1        <= 3'b100;
            t2        <= 3'b100;
            p1        <= 2'b10;
            p2        <= 2'b10;
            remaining <= CNT_W'(ALLRED_TICKS - 1);
        end else begin
            phase_q   <= phase_d;
            elapsed_q <= elapsed_d;
            div_q     <= div_d;
            served_q  <= served_d;
            blink_q   <= blink_d;
            ped_wait1 <= wait1_d;
            ped_wait2 <= wait2_d;
            t1        <= t1_d;
            t2        <= t2_d;
            p1        <= p1_d;
            p2        <= p2_d;
            remaining <= remaining_d;
        end
    end

    assign state = phase_q;

    // Next phase, divider, elapsed counter, blink and request latches.
    always_comb begin
        phase_d   = phase_q;
        elapsed_d = elapsed_q;
        div_d     = div_q;
        served_d  = served_q;
        blink_d   = blink_q;
        wait1_d   = ped_wait1;
        wait2_d   = ped_wait2;
        tick      = 1'b0;
        force_ok  = 1'b0;

        if (enable) begin
            tick  = (div_q == DIV_W'(TICK_DIV - 1));
            div_d = tick ? '0 : div_q + DIV_W'(1);

            if (ped_req1) wait1_d = 1'b1;
            if (ped_req2) wait2_d = 1'b1;

            // Manual advance is blocked while walk/flash is being shown.
            force_ok = force_next && (phase_q == PH_G1 || phase_q == PH_G2) &&
                       !(served_q && elapsed_q < CNT_W'(WALK_TICKS + FLASH_TICKS));

            if (force_ok) begin
                phase_d   = next_phase(phase_q);
                elapsed_d = '0;
            end else if (tick) begin
                if (elapsed_q == phase_len(phase_q) - CNT_W'(1)) begin
                    phase_d   = next_phase(phase_q);
                    elapsed_d = '0;
                end else begin
                    elapsed_d = elapsed_q + CNT_W'(1);
                end
                blink_d = (elapsed_d == CNT_W'(WALK_TICKS)) ? 1'b1 : ~blink_q;
            end

            // Green entry serves the pending request, including a same-cycle press.
            if (phase_d != phase_q) begin
                served_d = 1'b0;
                if (phase_d == PH_G1) begin
                    served_d = ped_wait1 | ped_req1;
                    wait1_d  = 1'b0;
                end
                if (phase_d == PH_G2) begin
                    served_d = ped_wait2 | ped_req2;
                    wait2_d  = 1'b0;
                end
            end
        end

        // Illegal encodings recover to all-red.
        if (phase_q > PH_R2) begin
            phase_d   = PH_R2;
            elapsed_d = '0;
            served_d  = 1'b0;
        end
    end

    // Lamp and remaining decode from the next-state values.
    always_comb begin
        t1_d = 3'b100;
        t2_d = 3'b100;
        p1_d = 2'b10;
        p2_d = 2'b10;
        case (phase_d)
            PH_G1:   t1_d = 3'b001;
            PH_Y1:   t1_d = 3'b010;
            PH_G2:   t2_d = 3'b001;
            PH_Y2:   t2_d = 3'b010;
            default: ;
        endcase
        if (served_d && phase_d == PH_G1) p1_d = ped_lamp(elapsed_d, blink_d);
        if (served_d && phase_d == PH_G2) p2_d = ped_lamp(elapsed_d, blink_d);
        remaining_d = phase_len(phase_d) - CNT_W'(1) - elapsed_d;
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios followed by random
// stimulus, every cycle compared against a tick-counting reference model.
module tb_traffic_phase_controller;

    localparam int unsigned TD = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned GT = 8;
    localparam int unsigned YT = 2;
    localparam int unsigned AT = 1;
    localparam int unsigned WT = 3;
    localparam int unsigned FT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          ped_req1;
    logic          ped_req2;
    logic          force_next;
    logic [2:0]    t1, t2;
    logic [1:0]    p1, p2;
    logic          ped_wait1, ped_wait2;
    logic [2:0]    state;
    logic [CW-1:0] remaining;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase index, ticks spent in phase, enabled-cycle count.
    int m_phase, m_ticks, en_count;
    bit m_served, m_w1, m_w2;
    int dur[6]             = '{GT, YT, AT, GT, YT, AT};
    logic [2:0] t1_tab[6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] t2_tab[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    traffic_phase_controller #(
        .TICK_DIV(TD), .CNT_W(CW), .GREEN_TICKS(GT), .YELLOW_TICKS(YT),
        .ALLRED_TICKS(AT), .WALK_TICKS(WT), .FLASH_TICKS(FT)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .ped_req1(ped_req1), .ped_req2(ped_req2), .force_next(force_next),
        .t1(t1), .t2(t2), .p1(p1), .p2(p2),
        .ped_wait1(ped_wait1), .ped_wait2(ped_wait2),
        .state(state), .remaining(remaining)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_p(input int green);
        if (m_served && m_phase == green) begin
            if (m_ticks < int'(WT)) return 2'b01;
            if (m_ticks < int'(WT + FT)) return (((m_ticks - int'(WT)) % 2) == 0) ? 2'b10 : 2'b00;
        end
        return 2'b10;
    endfunction

    task automatic model_reset();
        m_phase  = 5;
        m_ticks  = 0;
        en_count = 0;
        m_served = 0;
        m_w1     = 0;
        m_w2     = 0;
    endtask

    task automatic model_update(input bit en, input bit r1, input bit r2, input bit fn);
        int  nxt;
        bit  tk, green, in_wf;
        if (!en) return;
        tk    = (en_count % int'(TD)) == int'(TD) - 1;
        en_count++;
        green = (m_phase == 0 || m_phase == 3);
        in_wf = green && m_served && m_ticks < int'(WT + FT);
        nxt   = m_phase;
        if (fn && green && !in_wf) begin
            nxt     = (m_phase + 1) % 6;
            m_ticks = 0;
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == dur[m_phase]) begin
                nxt     = (m_phase + 1) % 6;
                m_ticks = 0;
            end
        end
        if (r1) m_w1 = 1;
        if (r2) m_w2 = 1;
        if (nxt != m_phase) begin
            m_served = 0;
            if (nxt == 0) begin m_served = m_w1; m_w1 = 0; end
            if (nxt == 3) begin m_served = m_w2; m_w2 = 0; end
        end
        m_phase = nxt;
    endtask

    task automatic check_all();
        chk("state",     32'(state),     32'(m_phase));
        chk("remaining", 32'(remaining), 32'(dur[m_phase] - 1 - m_ticks));
        chk("t1",        32'(t1),        32'(t1_tab[m_phase]));
        chk("t2",        32'(t2),        32'(t2_tab[m_phase]));
        chk("p1",        32'(p1),        32'(exp_p(0)));
        chk("p2",        32'(p2),        32'(exp_p(3)));
        chk("ped_wait1", 32'(ped_wait1), 32'(m_w1));
        chk("ped_wait2", 32'(ped_wait2), 32'(m_w2));
    endtask

    task automatic step(input bit en, input bit r1, input bit r2, input bit fn);
        enable     = en;
        ped_req1   = r1;
        ped_req2   = r2;
        force_next = fn;
        model_update(en, r1, r2, fn);
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic run_until(input int ph, input int tk);
        int guard = 0;
        while (!(m_phase == ph && m_ticks == tk)) begin
            step(1, 0, 0, 0);
            guard++;
            if (guard > 400) begin
                n_vec++;
                n_err++;
                $error("FAIL timeout waiting phase=%0d ticks=%0d observed_state=%0d", ph, tk, state);
                break;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        ped_req1   = 1'b0;
        ped_req2   = 1'b0;
        force_next = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Free-running cycle with no requests.
        run(100);

        // Request 1 raised during R2 and served at G1 entry.
        run_until(5, 0);
        step(1, 1, 0, 0);
        chk("wait1_set", 32'(ped_wait1), 32'd1);
        run_until(2, 0);

        // Early advance from an unserved G2 at elapsed=1.
        run_until(3, 1);
        step(1, 0, 0, 1);
        chk("force_state", 32'(state), 32'd4);
        chk("force_rem",   32'(remaining), 32'(YT - 1));

        // Early advance ignored during walk in a served G1.
        step(1, 1, 0, 0);
        run_until(0, 2);
        step(1, 0, 0, 1);
        chk("force_ignored", 32'(state), 32'd0);

        // Freeze for 20 cycles mid-Y1.
        run_until(1, 0);
        run(2);
        for (int i = 0; i < 20; i++) step(0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
        run_until(2, 0);

        // Request 2 held high through R1 and G2.
        while (m_phase == 2 || m_phase == 3) step(1, 0, 1, 0);
        chk("wait2_relatched", 32'(ped_wait2), 32'd1);
        run_until(3, 0);
        chk("wait2_served", 32'(ped_wait2), 32'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(9) != 0, $urandom_range(19) == 0,
                 $urandom_range(19) == 0, $urandom_range(19) == 0);

        // Asynchronous reset mid-walk in G1.
        step(1, 1, 0, 0);
        run_until(0, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_state", 32'(state), 32'd5);
        chk("rst_t1",    32'(t1), 32'b100);
        chk("rst_p1",    32'(p1), 32'b10);
        chk("rst_rem",   32'(remaining), 32'd0);
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
